bus_data_fifo: RTL and testbench
================================

Name: bus_data_fifo

Overview:
- Downstream consumer of the 8-bit incrementing bus-data stage.
- Captures each data word qualified by a valid strobe (the stage's enable) into a small synchronous FIFO.
- Presents the words on a first-word-fall-through valid/ready port for a checker or scoreboard.
- The upstream stage cannot be stalled, so words arriving while the FIFO is full are dropped and counted.

Parameters:
- DATA_W, 8, width of a data word.
- DEPTH, 8, number of FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream data qualifier (upstream enable); a word is offered every cycle it is high.
- in_data  input  DATA_W  upstream data word.
- out_valid  output  1  FIFO holds at least one word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_W  head-of-FIFO word.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set on the first dropped word.
- drop_cnt  output  8  number of dropped words, saturating at 255.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state changes on the posedge of clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0.
  - out_valid = 0, overflow = 0, drop_cnt = 0, out_data = 0.
  - Memory contents are not reset.
- Reset priority:
  - rst wins over all other inputs. in_valid and out_ready are ignored in any cycle rst is high.
  - Asserting rst mid-operation discards all stored words.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop).
- On push, mem[wr_ptr] <= in_data and wr_ptr increments modulo DEPTH.
- On pop, rd_ptr increments modulo DEPTH.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Outputs: out_valid = !empty. out_data = mem[rd_ptr] when !empty, otherwise 0.
- Latency: a word pushed at edge N appears on out_data/out_valid immediately after edge N, so it can be popped at edge N+1. There is no same-cycle bypass from in_data to out_data.
- Empty with in_valid = 1 and out_ready = 1: push only; no pop because out_valid = 0.
- Full with in_valid = 1 and pop: push and pop both occur; count stays at DEPTH; no drop.
- Full with in_valid = 1 and no pop: word dropped, pointers unchanged, overflow <= 1, drop_cnt <= drop_cnt + 1 unless already 255.
- overflow is cleared only by rst.
- out_ready while empty has no effect; rd_ptr does not move.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is strictly FIFO across the wrap.
- Width rule: data is stored unmodified. No arithmetic is applied to data.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low with in_valid = 0 -> empty = 1, full = 0, count = 0, out_valid = 0, out_data = 0, overflow = 0, drop_cnt = 0.
- Basic stream: out_ready = 0; in_valid = 1 for 3 cycles with in_data = 0x01, 0x02, 0x03 -> count = 3; out_data = 0x01 one cycle after the first push. Then out_ready = 1 -> 0x01, 0x02, 0x03 popped in order; empty = 1 after the third pop.
- Overflow: DEPTH = 8, out_ready = 0; push 10 words 0x00..0x09 -> full = 1 after 8 pushes, overflow = 1, drop_cnt = 2. Draining yields 0x00..0x07 only.
- Full with simultaneous push and pop: from full, in_valid = 1 and out_ready = 1 for 4 cycles with data 0x20..0x23 -> count stays 8, drop_cnt unchanged, all 4 words accepted. Draining after 0x04..0x07 yields 0x20..0x23.
- Wrap and saturation:
  - Alternate push and pop for 20 words -> output sequence matches input, count <= 1.
  - Then hold full with out_ready = 0 and in_valid = 1 for 300 cycles -> drop_cnt = 255 and stays at 255.
- Reset mid-operation: with count = 5 and overflow = 1, pulse rst for 1 cycle while in_valid = 1 -> next cycle count = 0, empty = 1, overflow = 0, drop_cnt = 0; the word presented during rst is not stored.

Source files
------------

// File: rtl/bus_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_data_fifo
// Brief    : First-word-fall-through FIFO that captures a non-stallable
//            valid-qualified data stream, dropping and counting overflow words.
// Revision : 1.0 - initial release
// ============================================================================
module bus_data_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]     c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0]     c_cnt_one = CW'(1);
    localparam logic [AW-1:0]     c_ptr_one = AW'(1);
    localparam logic [7:0]        c_drop_max = 8'hFF;
    localparam logic [DATA_W-1:0] c_data_zero = '0;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    // Storage is not reset; only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_drop_max) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? c_data_zero : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_data_fifo
// Brief    : Directed self-checking bench for bus_data_fifo (DATA_W=8, DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_data_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_total;
    int n_bad;

    bus_data_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Basic stream
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        chk("basic_first_valid", 32'(out_valid), 32'd1);
        chk("basic_first_data", 32'(out_data), 32'h01);
        in_data = 8'h02;
        step();
        in_data = 8'h03;
        step();
        in_valid = 1'b0;
        chk("basic_count3", 32'(count), 32'd3);
        chk("basic_head", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk("basic_pop", 32'(out_data), 32'(k));
            step();
        end
        out_ready = 1'b0;
        chk("basic_empty", 32'(empty), 32'd1);

        // Overflow: 10 pushes into 8 entries
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            if (i == 7) begin
                chk("ovf_full8", 32'(full), 32'd1);
                chk("ovf_ovf_clear", 32'(overflow), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop2", 32'(drop_cnt), 32'd2);

        // Full with simultaneous push and pop: pops 0x00..0x03
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h20 + 8'(i);
            chk("pp_pop", 32'(out_data), 32'(i));
            step();
            chk("pp_count", 32'(count), 32'd8);
        end
        in_valid = 1'b0;
        chk("pp_drop", 32'(drop_cnt), 32'd2);
        begin
            logic [7:0] exp_q [8];
            exp_q = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h20, 8'h21, 8'h22, 8'h23};
            for (int i = 0; i < 8; i++) begin
                chk("pp_drain", 32'(out_data), 32'(exp_q[i]));
                step();
            end
        end
        chk("pp_empty", 32'(empty), 32'd1);

        // Empty with push and ready: push only
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        chk("er_count", 32'(count), 32'd1);
        chk("er_data", 32'(out_data), 32'h77);
        step();
        chk("er_popped", 32'(count), 32'd0);
        step();
        step();
        chk("idle_ready_count", 32'(count), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h78;
        step();
        in_valid = 1'b0;
        chk("idle_ready_head", 32'(out_data), 32'h78);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_ready_empty", 32'(empty), 32'd1);

        // Alternating push/pop across pointer wrap
        for (int k = 0; k < 20; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            in_data   = 8'h40 + 8'(k);
            step();
            chk("alt_data", 32'(out_data), 32'h40 + 32'(k));
            chk("alt_count1", 32'(count), 32'd1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            chk("alt_count0", 32'(count), 32'd0);
        end
        out_ready = 1'b0;

        // Hold full for 300 cycles: drop counter saturates
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            step();
            if (i == 17) chk("sat_drop12", 32'(drop_cnt), 32'd12);
        end
        chk("sat_drop255", 32'(drop_cnt), 32'd255);
        chk("sat_full", 32'(full), 32'd1);
        chk("sat_head", 32'(out_data), 32'd0);
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        chk("sat_hold", 32'(drop_cnt), 32'd255);

        // Reset mid-operation with count = 5 and overflow set
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        chk("mid_count5", 32'(count), 32'd5);
        chk("mid_ovf1", 32'(overflow), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_count0", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_ovf0", 32'(overflow), 32'd0);
        chk("mid_drop0", 32'(drop_cnt), 32'd0);
        chk("mid_data0", 32'(out_data), 32'd0);
        step();
        chk("mid_not_stored", 32'(count), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        chk("post_rst_data", 32'(out_data), 32'h55);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
